aes_load_ctrl: RTL and testbench

AES_LOAD_CTRL -- requirements
Module: aes_load_ctrl

---
 rtl/aes_load_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_aes_load_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_load_ctrl.sv
// aes_load_ctrl: turns an opcode+data byte stream into AES core key/state loads,
// a launch pulse, and a ciphertext byte stream. Define AES_LOAD_CTRL_KEY_CACHE_EN for key caching/replay.
module aes_load_ctrl #(
  parameter logic [7:0] CMD_KEY   = 8'hA5,
  parameter logic [7:0] CMD_STATE = 8'h5A,
  parameter logic [7:0] CMD_START = 8'hC3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_byte,
  output logic         in_ready,
  output logic         ld_key_valid,
  output logic [7:0]   ld_key_byte,
  input  logic         ld_key_ready,
  output logic         ld_state_valid,
  output logic [7:0]   ld_state_byte,
  input  logic         ld_state_ready,
  output logic         start,
  input  logic [127:0] core_state_out,
  input  logic         core_done,
  output logic         out_valid,
  output logic [7:0]   out_byte,
  input  logic         out_ready,
  output logic         busy,
  output logic         err
);

`ifdef AES_LOAD_CTRL_KEY_CACHE_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_KEY, ST_STATE, ST_REPLAY, ST_LAUNCH, ST_WAIT, ST_SEND
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_KEY, ST_STATE, ST_LAUNCH, ST_WAIT, ST_SEND
  } state_t;
`endif

  state_t         state;
  state_t         state_nxt;
  logic [4:0]     cnt;
  logic           key_loaded;
  logic           state_loaded;
  logic [127:0]   buffer;
  logic           rdy_en;
  logic           err_nxt;
  logic           key_xfer;
  logic           state_xfer;
  logic           out_xfer;
  logic           capture;
`ifdef AES_LOAD_CTRL_KEY_CACHE_EN
  logic [255:0]   cache;
`endif

  assign key_xfer   = ld_key_valid & ld_key_ready;
  assign state_xfer = ld_state_valid & ld_state_ready;
  assign out_xfer   = out_valid & out_ready;
  assign capture    = (state == ST_WAIT) & core_done;
  assign busy       = (state != ST_IDLE);

  // rdy_en keeps in_ready low while reset is held and for the cycle of release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rdy_en <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    ld_key_valid   = 1'b0;
    ld_key_byte    = 8'h00;
    ld_state_valid = 1'b0;
    ld_state_byte  = 8'h00;
    start          = 1'b0;
    out_valid      = 1'b0;
    out_byte       = 8'h00;
    err_nxt        = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en) begin
          if (in_byte == CMD_KEY) begin
            state_nxt = ST_KEY;
          end else if (in_byte == CMD_STATE) begin
            state_nxt = ST_STATE;
          end else if (in_byte == CMD_START && key_loaded && state_loaded) begin
`ifdef AES_LOAD_CTRL_KEY_CACHE_EN
            state_nxt = ST_REPLAY;
`else
            state_nxt = ST_LAUNCH;
`endif
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_KEY: begin
        ld_key_valid = in_valid;
        ld_key_byte  = in_byte;
        in_ready     = ld_key_ready;
        if (in_valid && ld_key_ready && cnt == 5'd31) state_nxt = ST_IDLE;
      end
      ST_STATE: begin
        ld_state_valid = in_valid;
        ld_state_byte  = in_byte;
        in_ready       = ld_state_ready;
        if (in_valid && ld_state_ready && cnt == 5'd15) state_nxt = ST_IDLE;
      end
`ifdef AES_LOAD_CTRL_KEY_CACHE_EN
      ST_REPLAY: begin
        ld_key_valid = 1'b1;
        ld_key_byte  = cache[255:248];
        if (ld_key_ready && cnt == 5'd31) state_nxt = ST_LAUNCH;
      end
`endif
      ST_LAUNCH: begin
        start     = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_byte  = buffer[127:120];
        if (out_ready && cnt == 5'd15) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Any state change restarts the shared transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 5'd0;
    end else if (state_nxt != state) begin
      cnt <= 5'd0;
    end else if (key_xfer || state_xfer || out_xfer) begin
      cnt <= cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_loaded   <= 1'b0;
      state_loaded <= 1'b0;
    end else begin
      if (state == ST_KEY && key_xfer && cnt == 5'd31) begin
        key_loaded <= 1'b1;
`ifndef AES_LOAD_CTRL_KEY_CACHE_EN
      end else if (capture) begin
        key_loaded <= 1'b0;
`endif
      end
      if (state == ST_STATE && state_xfer && cnt == 5'd15) begin
        state_loaded <= 1'b1;
      end else if (capture) begin
        state_loaded <= 1'b0;
      end
    end
  end

  // Buffer shifts left so the next outgoing byte is always in the top lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer <= 128'd0;
    end else if (capture) begin
      buffer <= core_state_out;
    end else if (out_xfer) begin
      buffer <= {buffer[119:0], 8'h00};
    end
  end

`ifdef AES_LOAD_CTRL_KEY_CACHE_EN
  // Replay rotates rather than shifts so the cached key survives for the next launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache <= 256'd0;
    end else if (state == ST_KEY && key_xfer) begin
      cache <= {cache[247:0], in_byte};
    end else if (state == ST_REPLAY && key_xfer) begin
      cache <= {cache[247:0], cache[255:248]};
    end
  end
`endif

endmodule

// File: tb/tb_aes_load_ctrl.sv
// tb_aes_load_ctrl: self-checking bench for aes_load_ctrl with a behavioural AES core stand-in.
// Expectations adapt to AES_LOAD_CTRL_KEY_CACHE_EN when it is defined for the build.
module tb_aes_load_ctrl;

  localparam logic [7:0]   CMD_KEY   = 8'hA5;
  localparam logic [7:0]   CMD_STATE = 8'h5A;
  localparam logic [7:0]   CMD_START = 8'hC3;
  localparam logic [255:0] KAT_KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT    = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [7:0]   in_byte;
  logic         in_ready;
  logic         ld_key_valid;
  logic [7:0]   ld_key_byte;
  logic         ld_key_ready;
  logic         ld_state_valid;
  logic [7:0]   ld_state_byte;
  logic         ld_state_ready;
  logic         start;
  logic [127:0] core_state_out;
  logic         core_done;
  logic         out_valid;
  logic [7:0]   out_byte;
  logic         out_ready;
  logic         busy;
  logic         err;

  int total = 0;
  int bad = 0;

  aes_load_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .ld_key_valid(ld_key_valid), .ld_key_byte(ld_key_byte), .ld_key_ready(ld_key_ready),
    .ld_state_valid(ld_state_valid), .ld_state_byte(ld_state_byte), .ld_state_ready(ld_state_ready),
    .start(start), .core_state_out(core_state_out), .core_done(core_done),
    .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Stand-in cipher: the known FIPS-197 AES-256 answer for the reference vector, a keyed mix otherwise
  function automatic logic [127:0] model_cipher(input logic [255:0] k, input logic [127:0] p);
    if (k == KAT_KEY && p == KAT_PT) return KAT_CT;
    return p ^ k[255:128] ^ {k[63:0], k[127:64]} ^ 128'h3c3c_a5a5_0f0f_9696_c3c3_5a5a_f0f0_6969;
  endfunction

  // Core model: shift-register loads, fixed latency, core_done held until the next start
  logic [255:0] core_key;
  logic [127:0] core_pt;
  logic         core_busy;
  int           core_lat;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_key       <= '0;
      core_pt        <= '0;
      core_done      <= 1'b0;
      core_state_out <= '0;
      core_busy      <= 1'b0;
      core_lat       <= 0;
    end else begin
      if (ld_key_valid && ld_key_ready) core_key <= {core_key[247:0], ld_key_byte};
      if (ld_state_valid && ld_state_ready) core_pt <= {core_pt[119:0], ld_state_byte};
      if (start) begin
        core_done <= 1'b0;
        core_busy <= 1'b1;
        core_lat  <= 4;
      end else if (core_busy) begin
        if (core_lat == 0) begin
          core_done      <= 1'b1;
          core_state_out <= model_cipher(core_key, core_pt);
          core_busy      <= 1'b0;
        end else begin
          core_lat <= core_lat - 1;
        end
      end
    end
  end

  int key_bytes = 0;
  int state_bytes = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  logic [7:0] rx_q[$];
  always @(posedge clk) begin
    if (ld_key_valid && ld_key_ready) key_bytes <= key_bytes + 1;
    if (ld_state_valid && ld_state_ready) state_bytes <= state_bytes + 1;
    if (start) start_cnt <= start_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (out_valid && out_ready) rx_q.push_back(out_byte);
  end

  // Stalled output byte must hold until it is accepted
  logic [7:0] prev_byte = 8'h00;
  logic       prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n && prev_stall && out_valid) checkOutput("out_byte_hold", out_byte, prev_byte);
    prev_stall = rst_n && out_valid && !out_ready;
    prev_byte  = out_byte;
  end

  int out_mode = 0;
  int ld_mode = 0;
  initial begin
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    ld_key_ready = 1'b1;
    ld_state_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      case (out_mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (ld_mode == 0) begin
        ld_key_ready = 1'b1;
        ld_state_ready = 1'b1;
      end else begin
        ld_key_ready = 1'($urandom_range(0, 1));
        ld_state_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Offers one byte upstream; starts and ends just after a falling edge
  task automatic applyStimulus(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_byte = b;
    for (int n = 0; n < 300; n++) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) break;
    end
    in_valid = 1'b0;
    in_byte = 8'h00;
    if (!acc) begin
      total++;
      bad++;
      $display("[TB] FAIL in_handshake_timeout: got no in_ready, expected acceptance of %0h", b);
    end
  endtask

  task automatic load_and_start(input logic [255:0] k, input logic [127:0] p);
    applyStimulus(CMD_KEY);
    for (int i = 0; i < 32; i++) applyStimulus(k[255-8*i -: 8]);
    applyStimulus(CMD_STATE);
    for (int i = 0; i < 16; i++) applyStimulus(p[127-8*i -: 8]);
    applyStimulus(CMD_START);
  endtask

  task automatic collect(input string name, input logic [127:0] ct);
    int n;
    n = 0;
    while (rx_q.size() < 16 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    checkOutput({name, "_count"}, 128'(rx_q.size()), 128'd16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", name, i), rx_q[i], ct[127-8*i -: 8]);
    checkOutput({name, "_busy_after"}, busy, 1'b0);
    rx_q.delete();
  endtask

  typedef struct {
    logic [7:0] op;
    logic       exp_err;
    logic       exp_busy;
  } opcode_vec_t;

  initial begin
    opcode_vec_t vecs[6];
    int s0, e0, k0, t0;
    logic [255:0] rk;
    logic [127:0] rp;

    vecs[0] = '{8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b0};
    vecs[2] = '{CMD_START, 1'b1, 1'b0};
    vecs[3] = '{8'hA4, 1'b1, 1'b0};
    vecs[4] = '{8'h5B, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    #1;
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_start", start, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready_low", in_ready, 1'b0);
    @(negedge clk);
    checkOutput("release_in_ready_high", in_ready, 1'b1);

    $display("[TB] illegal opcode table");
    s0 = start_cnt;
    k0 = key_bytes + state_bytes;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op);
      checkOutput($sformatf("op%0h_err", vecs[i].op), err, vecs[i].exp_err);
      checkOutput($sformatf("op%0h_busy", vecs[i].op), busy, vecs[i].exp_busy);
      @(negedge clk);
      checkOutput($sformatf("op%0h_err_clear", vecs[i].op), err, 1'b0);
    end
    checkOutput("bad_op_no_core_xfer", 128'(key_bytes + state_bytes - k0), 128'd0);
    checkOutput("bad_op_no_start", 128'(start_cnt - s0), 128'd0);

    $display("[TB] start with only state loaded");
    applyStimulus(CMD_STATE);
    for (int i = 0; i < 16; i++) applyStimulus(KAT_PT[127-8*i -: 8]);
    applyStimulus(CMD_START);
    checkOutput("state_only_err", err, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("state_only_no_start", 128'(start_cnt - s0), 128'd0);
    checkOutput("state_only_idle", busy, 1'b0);

    $display("[TB] reference vector, out_ready held high");
    s0 = start_cnt;
    e0 = err_cnt;
    load_and_start(KAT_KEY, KAT_PT);
    collect("kat", KAT_CT);
    checkOutput("kat_one_start", 128'(start_cnt - s0), 128'd1);
    checkOutput("kat_no_err", 128'(err_cnt - e0), 128'd0);

    $display("[TB] reference vector, out_ready 1-of-3");
    out_mode = 1;
    s0 = start_cnt;
    load_and_start(KAT_KEY, KAT_PT);
    collect("kat_stall", KAT_CT);
    checkOutput("kat_stall_one_start", 128'(start_cnt - s0), 128'd1);
    out_mode = 0;

    $display("[TB] second start with fresh plaintext only");
    s0 = start_cnt;
    e0 = err_cnt;
    k0 = key_bytes;
    applyStimulus(CMD_STATE);
    for (int i = 0; i < 16; i++) applyStimulus(KAT_PT[127-8*i -: 8]);
    applyStimulus(CMD_START);
`ifdef AES_LOAD_CTRL_KEY_CACHE_EN
    collect("replay", KAT_CT);
    checkOutput("replay_key_bytes", 128'(key_bytes - k0), 128'd32);
    checkOutput("replay_one_start", 128'(start_cnt - s0), 128'd1);
    checkOutput("replay_no_err", 128'(err_cnt - e0), 128'd0);
`else
    checkOutput("no_cache_err", err, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("no_cache_no_start", 128'(start_cnt - s0), 128'd0);
    checkOutput("no_cache_no_key_bytes", 128'(key_bytes - k0), 128'd0);
`endif

    $display("[TB] reset in the middle of a key load");
    applyStimulus(CMD_KEY);
    for (int i = 0; i < 10; i++) applyStimulus(KAT_KEY[255-8*i -: 8]);
    checkOutput("mid_key_busy", busy, 1'b1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_byte = 8'hFF;
    #1;
    checkOutput("mid_rst_in_ready", in_ready, 1'b0);
    checkOutput("mid_rst_ld_key_valid", ld_key_valid, 1'b0);
    checkOutput("mid_rst_ld_key_byte", ld_key_byte, 8'h00);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_out_byte", out_byte, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    in_byte = 8'h00;
    rst_n = 1'b1;
    @(negedge clk);
    s0 = start_cnt;
    applyStimulus(CMD_START);
    checkOutput("post_rst_nothing_loaded_err", err, 1'b1);
    e0 = err_cnt + 1;
    load_and_start(KAT_KEY, KAT_PT);
    collect("post_rst", KAT_CT);
    checkOutput("post_rst_one_start", 128'(start_cnt - s0), 128'd1);
    checkOutput("post_rst_no_err", 128'(err_cnt - e0), 128'd0);

    $display("[TB] randomized loads with random backpressure");
    out_mode = 2;
    ld_mode = 1;
    for (int it = 0; it < 6; it++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      s0 = start_cnt;
      t0 = key_bytes;
      load_and_start(rk, rp);
      collect($sformatf("rand%0d", it), model_cipher(rk, rp));
      checkOutput($sformatf("rand%0d_one_start", it), 128'(start_cnt - s0), 128'd1);
`ifdef AES_LOAD_CTRL_KEY_CACHE_EN
      checkOutput($sformatf("rand%0d_key_bytes", it), 128'(key_bytes - t0), 128'd64);
`else
      checkOutput($sformatf("rand%0d_key_bytes", it), 128'(key_bytes - t0), 128'd32);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
